// File: rtl/pwm_duty_sequencer.sv
// Duty-word sequencer for the Pwm block: static level, sawtooth or triangle ramps.
// Duty only changes on the edge that ends a PWM period, so the PWM never glitches.
//
// state     | meaning
// ST_STATIC | duty follows i_static_duty at every period boundary
// ST_UP     | ramping up (saw-up, or rising half of triangle)
// ST_DOWN   | ramping down (saw-down, or falling half of triangle)
module pwm_duty_sequencer #(
  parameter int HOLD_PERIODS = 8
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_en,
  input  logic [1:0] i_mode,
  input  logic [3:0] i_static_duty,
  output logic [3:0] o_duty,
  output logic       o_dir,
  output logic       o_step,
  output logic [3:0] o_phase
);

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_PERIODS - 1);
  localparam logic [1:0] MODE_STATIC = 2'b00;
  localparam logic [1:0] MODE_TRI    = 2'b10;
  localparam logic [1:0] MODE_DOWN   = 2'b11;

  typedef enum logic [1:0] {ST_STATIC, ST_UP, ST_DOWN} state_t;

  state_t     r_state, w_state_nxt;
  logic [3:0] r_phase;
  logic [3:0] r_duty, w_duty_nxt;
  logic [7:0] r_hold, w_hold_nxt;
  logic [1:0] r_mode_q, w_mode_nxt;
  logic       r_step, w_step_nxt;
  logic       w_boundary;

  assign w_boundary = (r_phase == 4'd15);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_phase  <= 4'd0;
      r_duty   <= 4'd0;
      r_hold   <= 8'd0;
      r_mode_q <= MODE_STATIC;
      r_step   <= 1'b0;
      r_state  <= ST_STATIC;
    end else begin
      r_phase  <= r_phase + 4'd1;
      r_duty   <= w_duty_nxt;
      r_hold   <= w_hold_nxt;
      r_mode_q <= w_mode_nxt;
      r_step   <= w_step_nxt;
      r_state  <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_duty_nxt  = r_duty;
    w_hold_nxt  = r_hold;
    w_mode_nxt  = r_mode_q;
    w_step_nxt  = 1'b0;
    if (w_boundary && i_en) begin
      if (i_mode != r_mode_q) begin
        // A mode change restarts the hold count; ramps resume from the current duty.
        w_mode_nxt = i_mode;
        w_hold_nxt = 8'd0;
        case (i_mode)
          MODE_STATIC: begin
            w_state_nxt = ST_STATIC;
            w_duty_nxt  = i_static_duty;
          end
          MODE_DOWN: w_state_nxt = ST_DOWN;
          default:   w_state_nxt = ST_UP;
        endcase
      end else if (r_state == ST_STATIC) begin
        w_duty_nxt = i_static_duty;
        w_hold_nxt = 8'd0;
      end else if (r_hold != HOLD_LAST) begin
        w_hold_nxt = r_hold + 8'd1;
      end else begin
        w_hold_nxt = 8'd0;
        w_step_nxt = 1'b1;
        if (r_mode_q == MODE_TRI) begin
          // Endpoints turn around immediately so each is held for one step only.
          if (r_state == ST_UP) begin
            if (r_duty == 4'd15) begin
              w_duty_nxt  = 4'd14;
              w_state_nxt = ST_DOWN;
            end else begin
              w_duty_nxt = r_duty + 4'd1;
            end
          end else begin
            if (r_duty == 4'd0) begin
              w_duty_nxt  = 4'd1;
              w_state_nxt = ST_UP;
            end else begin
              w_duty_nxt = r_duty - 4'd1;
            end
          end
        end else if (r_state == ST_UP) begin
          w_duty_nxt = r_duty + 4'd1;
        end else begin
          w_duty_nxt = r_duty - 4'd1;
        end
      end
    end
  end

  assign o_duty  = r_duty;
  assign o_dir   = (r_state == ST_UP);
  assign o_step  = r_step;
  assign o_phase = r_phase;

endmodule
